// File: rtl/bus_pkg.sv
// Shared constants and FSM encoding for the bus frame receiver.
// Frame layout: EB 90 | CMD | LEN_H | LEN_L | STN | ADDR[4] | DATA.. | CKSUM
`timescale 1ns/1ps
package bus_pkg;
  localparam logic [7:0] SYNC1 = 8'hEB;
  localparam logic [7:0] SYNC2 = 8'h90;

  localparam int ADDR_W    = 11;
  localparam int BUF_DEPTH = 2048;

  localparam logic [ADDR_W-1:0] OFS_CMD   = 11'd2;
  localparam logic [ADDR_W-1:0] OFS_LEN   = 11'd3;
  localparam logic [ADDR_W-1:0] OFS_LEN_L = 11'd4;
  localparam logic [ADDR_W-1:0] OFS_STN   = 11'd5;
  localparam logic [ADDR_W-1:0] OFS_ADDR  = 11'd6;
  localparam logic [ADDR_W-1:0] MIN_LEN   = 11'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC2,
    ST_HDR,
    ST_PAYLOAD,
    ST_CKSUM,
    ST_HOLD
  } rx_state_t;

  // LEN_H may only use its low 3 bits; LEN must lie in [MIN_LEN, max_len].
  function automatic logic len_ok(input logic [7:0] len_h, input logic [7:0] len_l,
                                  input logic [ADDR_W-1:0] max_len);
    logic [ADDR_W-1:0] len;
    len = {len_h[2:0], len_l};
    return (len_h[7:3] == 5'd0) && (len >= MIN_LEN) && (len <= max_len);
  endfunction
endpackage

// File: rtl/bus_rx_timer.sv
// Inter-byte gap counter: cleared by each byte, counts while enabled,
// flags expiry on the TIMEOUT_CYC-th consecutive silent cycle.
`timescale 1ns/1ps
module bus_rx_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              count <= '0;
    else if (clear || !en)     count <= '0;
    else                       count <= count + 16'd1;
  end

  assign expire = en && !clear && (count == LAST);
endmodule

// File: rtl/bus_frame_rx.sv
// Frame receiver: hunts for EB 90, streams the frame into the rx buffer,
// validates LEN / station / checksum and holds frame_valid until frame_ack.
`timescale 1ns/1ps
module bus_frame_rx
  import bus_pkg::*;
#(
  parameter logic [7:0] STATION_ID  = 8'h01,
  parameter int         MAX_LEN     = 2042,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_valid,
  input  logic              frame_ack,
  output logic              rx_buf_wren,
  output logic [ADDR_W-1:0] rx_buf_waddr,
  output logic [7:0]        rx_buf_wdata,
  output logic              frame_valid,
  output logic [7:0]        frame_cmd,
  output logic [ADDR_W-1:0] frame_len,
  output logic              err_cksum,
  output logic              err_len,
  output logic              err_timeout,
  output logic              rx_overrun
);
  localparam logic [ADDR_W-1:0] MAX_LEN_W = ADDR_W'(MAX_LEN);

  rx_state_t         state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] len;
  logic [7:0]        len_h;
  logic [7:0]        cmd;
  logic [7:0]        sum;
  logic              stn_ok;
  logic              expire;
  logic              wr_hit;
  logic [ADDR_W-1:0] wr_addr;

  bus_rx_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (rx_byte_valid),
    .en      (state inside {ST_SYNC2, ST_HDR, ST_PAYLOAD, ST_CKSUM}),
    .expire  (expire)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_hit  = 1'b0;
    wr_addr = idx;
    if (rx_byte_valid) begin
      case (state)
        ST_IDLE: begin
          wr_hit  = (rx_byte == SYNC1);
          wr_addr = '0;
        end
        ST_SYNC2: begin
          if (rx_byte == SYNC1) begin
            wr_hit  = 1'b1;
            wr_addr = '0;
          end else begin
            wr_hit  = (rx_byte == SYNC2);
          end
        end
        ST_HDR, ST_PAYLOAD, ST_CKSUM: wr_hit = 1'b1;
        default: wr_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_buf_wren  <= 1'b0;
      rx_buf_waddr <= '0;
      rx_buf_wdata <= '0;
    end else begin
      rx_buf_wren <= wr_hit;
      if (wr_hit) begin
        rx_buf_waddr <= wr_addr;
        rx_buf_wdata <= rx_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      len         <= '0;
      len_h       <= '0;
      cmd         <= '0;
      sum         <= '0;
      stn_ok      <= 1'b0;
      frame_valid <= 1'b0;
      frame_cmd   <= '0;
      frame_len   <= '0;
      err_cksum   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      err_cksum   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      rx_overrun  <= 1'b0;
      if (expire) begin
        err_timeout <= 1'b1;
        state       <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (rx_byte_valid && rx_byte == SYNC1) begin
            idx   <= 11'd1;
            state <= ST_SYNC2;
          end
          ST_SYNC2: if (rx_byte_valid) begin
            if (rx_byte == SYNC2) begin
              idx   <= OFS_CMD;
              sum   <= '0;
              state <= ST_HDR;
            end else if (rx_byte == SYNC1) begin
              idx <= 11'd1;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_HDR: if (rx_byte_valid) begin
            idx <= idx + 11'd1;
            sum <= sum + rx_byte;
            if (idx == OFS_CMD) cmd <= rx_byte;
            if (idx == OFS_LEN) len_h <= rx_byte;
            if (idx == OFS_LEN_L) begin
              if (len_ok(len_h, rx_byte, MAX_LEN_W)) begin
                len   <= {len_h[2:0], rx_byte};
                state <= ST_PAYLOAD;
              end else begin
                err_len <= 1'b1;
                state   <= ST_IDLE;
              end
            end
          end
          ST_PAYLOAD: if (rx_byte_valid) begin
            idx <= idx + 11'd1;
            sum <= sum + rx_byte;
            if (idx == OFS_STN) stn_ok <= (rx_byte == STATION_ID);
            if (idx == len + OFS_LEN_L) state <= ST_CKSUM;
          end
          ST_CKSUM: if (rx_byte_valid) begin
            // A frame for another station is consumed silently, checksum or not.
            if (!stn_ok) begin
              state <= ST_IDLE;
            end else if (rx_byte != sum) begin
              err_cksum <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              frame_cmd <= cmd;
              frame_len <= len;
              state     <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            rx_overrun <= rx_byte_valid;
            // Entry cycle raises frame_valid one cycle after the CKSUM write.
            if (!frame_valid) begin
              frame_valid <= 1'b1;
            end else if (frame_ack) begin
              frame_valid <= 1'b0;
              state       <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bus_frame_rx.sv
// Self-checking bench for bus_frame_rx: directed and random frames checked
// against a frame-level reference model built from the frame format rules.
`timescale 1ns/1ps
module tb_bus_frame_rx;
  localparam int         TIMEOUT_CYC = 50000;
  localparam int         MAX_LEN     = 2042;
  localparam logic [7:0] STN         = 8'h01;

  typedef logic [7:0] bq_t[$];
  typedef enum {OUT_GOOD, OUT_LEN, OUT_CKSUM, OUT_FOREIGN} outcome_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_byte_valid = 1'b0;
  logic        frame_ack = 1'b0;
  logic        rx_buf_wren;
  logic [10:0] rx_buf_waddr;
  logic [7:0]  rx_buf_wdata;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [10:0] frame_len;
  logic        err_cksum, err_len, err_timeout, rx_overrun;

  int checks = 0;
  int errors = 0;

  bus_frame_rx #(.STATION_ID(STN), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .frame_ack     (frame_ack),
    .rx_buf_wren   (rx_buf_wren),
    .rx_buf_waddr  (rx_buf_waddr),
    .rx_buf_wdata  (rx_buf_wdata),
    .frame_valid   (frame_valid),
    .frame_cmd     (frame_cmd),
    .frame_len     (frame_len),
    .err_cksum     (err_cksum),
    .err_len       (err_len),
    .err_timeout   (err_timeout),
    .rx_overrun    (rx_overrun)
  );

  always #5 clk = ~clk;

  // Monitor: log buffer writes and count output pulses, sampled mid-cycle.
  int          cyc = 0, wr_cnt = 0, last_wr_cyc = 0, rise_cyc = 0;
  int          n_cks = 0, n_len = 0, n_to = 0, n_ovr = 0;
  logic [10:0] wa [4096];
  logic [7:0]  wd [4096];
  logic        fv_d = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_buf_wren) begin
      wa[wr_cnt % 4096] = rx_buf_waddr;
      wd[wr_cnt % 4096] = rx_buf_wdata;
      wr_cnt      = wr_cnt + 1;
      last_wr_cyc = cyc;
    end
    if (err_cksum)   n_cks = n_cks + 1;
    if (err_len)     n_len = n_len + 1;
    if (err_timeout) n_to  = n_to + 1;
    if (rx_overrun)  n_ovr = n_ovr + 1;
    if (frame_valid && !fv_d) rise_cyc = cyc;
    fv_d = frame_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_byte = b;
    rx_byte_valid = 1'b1;
    @(posedge clk); #1;
    rx_byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    @(posedge clk); #1;
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  // Builds leading EBs, 90, header, then (unless hdr_only) STN, data and checksum.
  task automatic build(input logic [7:0] cmd, input logic [7:0] lh, input logic [7:0] ll,
                       input logic [7:0] stn, input int n_lead, input logic [7:0] cks_err,
                       input bit hdr_only, output bq_t q);
    int len;
    logic [7:0] s;
    q = {};
    repeat (n_lead) q.push_back(8'hEB);
    q.push_back(8'h90);
    q.push_back(cmd); q.push_back(lh); q.push_back(ll);
    if (!hdr_only) begin
      len = int'(lh[2:0]) * 256 + int'(ll);
      q.push_back(stn);
      for (int i = 1; i < len; i++) q.push_back(8'($urandom));
      s = '0;
      for (int i = n_lead + 1; i < q.size(); i++) s = s + q[i];
      q.push_back(s + cks_err);
    end
  endtask

  task automatic run_frame(input string tag, input bq_t q, input int max_gap, input bit ack_it);
    int n_lead, s, len, last, b_w, b_cks, b_len, bad;
    bit len_bad;
    logic [7:0] sum;
    outcome_t out;
    logic [10:0] ea[$];
    logic [7:0]  ed[$];

    n_lead = 0;
    while (n_lead < q.size() && q[n_lead] == 8'hEB) n_lead++;
    s = n_lead - 1;
    for (int i = 0; i < n_lead; i++) begin ea.push_back(11'd0); ed.push_back(8'hEB); end
    len     = int'(q[s+3][2:0]) * 256 + int'(q[s+4]);
    len_bad = (q[s+3][7:3] != 5'd0) || (len < 5) || (len > MAX_LEN);
    last    = len_bad ? 4 : 5 + len;
    for (int i = 1; i <= last; i++) begin ea.push_back(11'(i)); ed.push_back(q[s+i]); end
    sum = '0;
    if (!len_bad) for (int k = 2; k <= 4 + len; k++) sum = sum + q[s+k];
    if (len_bad)               out = OUT_LEN;
    else if (q[s+5] != STN)    out = OUT_FOREIGN;
    else if (q[s+last] != sum) out = OUT_CKSUM;
    else                       out = OUT_GOOD;

    b_w = wr_cnt; b_cks = n_cks; b_len = n_len;
    foreach (q[i]) send(q[i], $urandom_range(0, max_gap));
    tick(3);

    check({tag, "_nwr"}, wr_cnt - b_w, ea.size());
    bad = 0;
    foreach (ea[i])
      if (wa[(b_w+i)%4096] !== ea[i] || wd[(b_w+i)%4096] !== ed[i]) bad++;
    check({tag, "_wrdata"}, bad, 0);
    check({tag, "_errlen"}, n_len - b_len, (out == OUT_LEN) ? 1 : 0);
    check({tag, "_errcks"}, n_cks - b_cks, (out == OUT_CKSUM) ? 1 : 0);
    check({tag, "_valid"}, frame_valid, (out == OUT_GOOD) ? 1 : 0);
    if (out == OUT_GOOD) begin
      check({tag, "_cmd"}, frame_cmd, q[s+2]);
      check({tag, "_len"}, frame_len, len);
      check({tag, "_vtime"}, rise_cyc - last_wr_cyc, 1);
      if (ack_it) begin
        do_ack();
        tick(2);
        check({tag, "_ackdrop"}, frame_valid, 0);
      end
    end
  endtask

  bq_t t1, q;

  initial begin
    t1 = '{8'hEB, 8'h90, 8'h03, 8'h00, 8'h05, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h1D};

    // Reset state
    tick(3);
    check("rst_valid", frame_valid, 0);
    check("rst_wren", rx_buf_wren, 0);
    check("rst_waddr", rx_buf_waddr, 0);
    check("rst_cmd", frame_cmd, 0);
    check("rst_len", frame_len, 0);
    check("rst_errs", {err_cksum, err_len, err_timeout, rx_overrun}, 0);
    reset_n = 1'b1;
    tick(2);

    // T1 basic good frame; an ack while idle must be ignored
    do_ack();
    run_frame("t1", t1, 0, 1);
    check("t1_cmd_lit", frame_cmd, 8'h03);
    check("t1_len_lit", frame_len, 11'd5);

    // T2 checksum error, then good frame
    q = t1; q[10] = 8'h1E;
    run_frame("t2", q, 1, 1);
    run_frame("t2_after", t1, 1, 1);

    // T3 length errors and length boundaries
    q = '{8'hEB, 8'h90, 8'h03, 8'h00, 8'h04};
    run_frame("t3_short", q, 0, 1);
    q = '{8'hEB, 8'h90, 8'h03, 8'h08, 8'h00};
    run_frame("t3_lenh", q, 0, 1);
    build(8'h07, 8'h07, 8'hFB, STN, 1, 8'h00, 1, q);
    run_frame("t3_2043", q, 0, 1);
    build(8'h07, 8'h07, 8'hFA, STN, 1, 8'h00, 0, q);
    run_frame("t3_2042", q, 0, 1);

    // T5 foreign station
    q = t1; q[5] = 8'h02; q[10] = 8'h1E;
    run_frame("t5", q, 1, 1);

    // T7 resync on repeated EB
    q = t1; q.push_front(8'hEB);
    run_frame("t7", q, 1, 1);

    // Random frames
    for (int n = 0; n < 30; n++) begin
      int len, r;
      logic [7:0] lh, ll, stn, ce;
      bit hdr;
      len = $urandom_range(5, 40);
      lh = 8'(len >> 8); ll = 8'(len);
      r = $urandom_range(0, 11);
      hdr = 0;
      if (r == 0) begin ll = 8'($urandom_range(0, 4)); lh = 8'h00; hdr = 1; end
      if (r == 1) begin lh = 8'h08 << $urandom_range(0, 4); hdr = 1; end
      stn = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(2, 255)) : STN;
      ce  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build(8'($urandom), lh, ll, stn, ($urandom_range(0, 4) == 0) ? 2 : 1, ce, hdr, q);
      run_frame("rand", q, 2, 1);
    end

    // T6 overrun while holding, ack with byte in the same cycle
    begin
      int b_o, b_w;
      run_frame("t6_hold", t1, 0, 0);
      b_o = n_ovr; b_w = wr_cnt;
      for (int i = 0; i < 3; i++) send(8'(8'hA0 + i), 1);
      tick(2);
      check("t6_ovr3", n_ovr - b_o, 3);
      check("t6_nowr", wr_cnt - b_w, 0);
      check("t6_still", frame_valid, 1);
      @(posedge clk); #1;
      frame_ack = 1'b1; rx_byte = 8'hEB; rx_byte_valid = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0; rx_byte_valid = 1'b0;
      tick(2);
      check("t6_ovr4", n_ovr - b_o, 4);
      check("t6_nowr2", wr_cnt - b_w, 0);
      check("t6_drop", frame_valid, 0);
      run_frame("t6_after", t1, 0, 1);
    end

    // Reset mid-frame discards the partial frame
    for (int i = 0; i < 6; i++) send(t1[i], 0);
    reset_n = 1'b0;
    tick(2);
    check("mrst_valid", frame_valid, 0);
    check("mrst_wren", rx_buf_wren, 0);
    reset_n = 1'b1;
    tick(1);
    run_frame("mrst_after", t1, 0, 1);

    // T4 inter-byte timeout
    begin
      int b_t;
      b_t = n_to;
      for (int i = 0; i < 8; i++) send(t1[i], 0);
      tick(TIMEOUT_CYC - 5);
      check("t4_early", n_to - b_t, 0);
      tick(20);
      check("t4_once", n_to - b_t, 1);
      check("t4_valid", frame_valid, 0);
      run_frame("t4_after", t1, 0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
